note_event_tracker: RTL and testbench

Parametrised, multi-voice note-duration tracker. Consumes the per-voice pitch/octave/on snapshot from the note decoder, measures each held note in BPM-locked sub-beat ticks, and emits one completed-note event per note into an output FIFO with a valid/ready handshake. Sits between the MIDI note decoder and the notation/storage back end, replacing the free-running per-voice duration counters with quantised, timestamped events.

---
 rtl/note_pkg.sv | 17 +
 rtl/event_fifo.sv | 48 ++++
 rtl/note_event_tracker.sv | 210 +++++++++++++++++++++
 tb/tb_note_event_tracker.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/note_pkg.sv
// Shared types for the note event tracker: voice FSM states, the event record
// at the default configuration, and the "no note latched" code.
package note_pkg;

   localparam logic [7:0] NOTE_OFF_CODE = 8'hFF;

   typedef enum logic {IDLE = 1'b0, HELD = 1'b1} voice_state_t;

   typedef struct packed {
      logic [2:0]  voice;
      logic [7:0]  note;
      logic [7:0]  duration;
      logic [31:0] start;
      logic        sat;
   } note_event_t;

endpackage

// File: rtl/event_fifo.sv
// Synchronous show-ahead FIFO: o_data is the head entry whenever o_empty is low.
// A push while full is ignored; the caller is expected to hold its data.
module event_fifo
   import note_pkg::*;
#(
   parameter int  DEPTH = 16,
   parameter type T     = note_event_t
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_push,
   input  T     i_data,
   input  logic i_pop,
   output T     o_data,
   output logic o_full,
   output logic o_empty
);

   localparam int AW = $clog2(DEPTH);

   T            r_mem [DEPTH];
   logic [AW:0] r_wp;
   logic [AW:0] r_rp;
   logic        w_push;
   logic        w_pop;

   // Pointers carry one extra wrap bit to tell full from empty.
   assign o_empty = (r_wp == r_rp);
   assign o_full  = (r_wp == {~r_rp[AW], r_rp[AW-1:0]});
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_data  = r_mem[r_rp[AW-1:0]];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wp <= '0;
         r_rp <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + (AW+1)'(1);
         if (w_pop)  r_rp <= r_rp + (AW+1)'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wp[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/note_event_tracker.sv
// Multi-voice note-duration tracker: BPM-locked tick generator, per-voice
// IDLE/HELD FSMs with one-entry pending slots, a priority arbiter and an event FIFO.
module note_event_tracker
   import note_pkg::*;
#(
   parameter int  NUM_VOICES     = 5,
   parameter int  CLK_HZ         = 100_000_000,
   parameter int  TICKS_PER_BEAT = 4,
   parameter int  DUR_WIDTH      = 8,
   parameter int  TS_WIDTH       = 32,
   parameter int  FIFO_DEPTH     = 16,
   localparam int VW             = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic                         valid_note_in,
   input  logic [NUM_VOICES-1:0][3:0]   note_value_array,
   input  logic [NUM_VOICES-1:0][3:0]   octave_count,
   input  logic [NUM_VOICES-1:0]        note_on_in,
   input  logic [7:0]                   bpm,
   output logic                         evt_valid_out,
   input  logic                         evt_ready_in,
   output logic [VW-1:0]                evt_voice_out,
   output logic [7:0]                   evt_note_out,
   output logic [DUR_WIDTH-1:0]         evt_duration_out,
   output logic [TS_WIDTH-1:0]          evt_start_out,
   output logic                         evt_sat_out,
   output logic                         overflow_out,
   output logic                         tick_out
);

   localparam longint unsigned PERIOD = 64'(CLK_HZ) * 64'd60;
   localparam int              ACC_W  = $clog2(PERIOD) + 2;
   localparam logic [ACC_W-1:0]     ACC_PERIOD = ACC_W'(PERIOD);
   localparam logic [DUR_WIDTH-1:0] DUR_MAX    = '1;

   // Same layout as note_event_t, sized by this instance's parameters.
   typedef struct packed {
      logic [VW-1:0]        voice;
      logic [7:0]           note;
      logic [DUR_WIDTH-1:0] duration;
      logic [TS_WIDTH-1:0]  start;
      logic                 sat;
   } evt_t;

   logic [ACC_W-1:0]    r_acc;
   logic [ACC_W-1:0]    w_sum;
   logic                r_tick;
   logic [TS_WIDTH-1:0] r_ts;
   logic [TS_WIDTH-1:0] w_ts_next;

   voice_state_t                         r_state [NUM_VOICES];
   voice_state_t                         w_state_nxt [NUM_VOICES];
   logic [NUM_VOICES-1:0][7:0]           r_note, w_note_nxt;
   logic [NUM_VOICES-1:0][TS_WIDTH-1:0]  r_start, w_start_nxt;
   logic [NUM_VOICES-1:0][DUR_WIDTH-1:0] r_dur, w_dur_nxt;
   logic [NUM_VOICES-1:0]                w_close;
   evt_t [NUM_VOICES-1:0]                w_close_evt;

   logic [NUM_VOICES-1:0] r_pend_vld;
   evt_t [NUM_VOICES-1:0] r_pend;
   logic [NUM_VOICES-1:0] w_grant;
   logic                  w_push;
   evt_t                  w_push_evt;
   logic                  r_ovf;

   evt_t w_head;
   evt_t w_out;
   logic w_full;
   logic w_empty;
   logic w_pop;

   assign w_sum     = r_acc + ACC_W'(bpm) * ACC_W'(TICKS_PER_BEAT);
   // r_tick is the pulse; the count steps at the end of the pulse cycle, so
   // anything starting in that cycle takes the post-increment count.
   assign w_ts_next = r_ts + TS_WIDTH'(r_tick);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_acc  <= '0;
         r_tick <= 1'b0;
         r_ts   <= '0;
      end else begin
         if (w_sum >= ACC_PERIOD) begin
            r_acc  <= w_sum - ACC_PERIOD;
            r_tick <= 1'b1;
         end else begin
            r_acc  <= w_sum;
            r_tick <= 1'b0;
         end
         if (r_tick) r_ts <= r_ts + TS_WIDTH'(1);
      end
   end

   always_comb begin
      logic [7:0]           note_in;
      logic [DUR_WIDTH-1:0] dur_now;
      note_in = '0;
      dur_now = '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         note_in = {note_value_array[v], octave_count[v]};
         dur_now = r_dur[v];
         if (r_state[v] == HELD && r_tick && r_dur[v] != DUR_MAX)
            dur_now = r_dur[v] + DUR_WIDTH'(1);
         w_state_nxt[v] = r_state[v];
         w_note_nxt[v]  = r_note[v];
         w_start_nxt[v] = r_start[v];
         w_dur_nxt[v]   = dur_now;
         w_close[v]     = 1'b0;
         w_close_evt[v] = '{voice: VW'(v), note: r_note[v], duration: dur_now,
                            start: r_start[v], sat: (dur_now == DUR_MAX)};
         if (valid_note_in) begin
            case (r_state[v])
               IDLE: if (note_on_in[v]) begin
                  w_state_nxt[v] = HELD;
                  w_note_nxt[v]  = note_in;
                  w_start_nxt[v] = w_ts_next;
                  w_dur_nxt[v]   = '0;
               end
               HELD: if (!note_on_in[v]) begin
                  w_close[v]     = 1'b1;
                  w_state_nxt[v] = IDLE;
               end else if (note_in != r_note[v]) begin
                  w_close[v]     = 1'b1;
                  w_note_nxt[v]  = note_in;
                  w_start_nxt[v] = w_ts_next;
                  w_dur_nxt[v]   = '0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk_in) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
         if (rst_in) begin
            r_state[v] <= IDLE;
            r_note[v]  <= NOTE_OFF_CODE;
            r_start[v] <= '0;
            r_dur[v]   <= '0;
         end else begin
            r_state[v] <= w_state_nxt[v];
            r_note[v]  <= w_note_nxt[v];
            r_start[v] <= w_start_nxt[v];
            r_dur[v]   <= w_dur_nxt[v];
         end
      end
   end

   // Lowest-indexed full slot wins; nothing moves while the FIFO is full.
   always_comb begin
      w_grant    = '0;
      w_push     = 1'b0;
      w_push_evt = '0;
      if (!w_full) begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            if (r_pend_vld[v] && !w_push) begin
               w_grant[v] = 1'b1;
               w_push     = 1'b1;
               w_push_evt = r_pend[v];
            end
         end
      end
   end

   // A slot being drained this cycle can accept a new close without loss.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_pend_vld <= '0;
         r_pend     <= '0;
         r_ovf      <= 1'b0;
      end else begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            if (w_close[v]) begin
               if (r_pend_vld[v] && !w_grant[v]) begin
                  r_ovf <= 1'b1;
               end else begin
                  r_pend_vld[v] <= 1'b1;
                  r_pend[v]     <= w_close_evt[v];
               end
            end else if (w_grant[v]) begin
               r_pend_vld[v] <= 1'b0;
            end
         end
      end
   end

   event_fifo #(.DEPTH(FIFO_DEPTH), .T(evt_t)) u_fifo (
      .i_clk   (clk_in),
      .i_rst   (rst_in),
      .i_push  (w_push),
      .i_data  (w_push_evt),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign evt_valid_out    = !w_empty;
   assign w_pop            = evt_valid_out && evt_ready_in;
   assign w_out            = w_empty ? '0 : w_head;
   assign evt_voice_out    = w_out.voice;
   assign evt_note_out     = w_out.note;
   assign evt_duration_out = w_out.duration;
   assign evt_start_out    = w_out.start;
   assign evt_sat_out      = w_out.sat;
   assign overflow_out     = r_ovf;
   assign tick_out         = r_tick;

endmodule

// File: tb/tb_note_event_tracker.sv
// Directed bench for note_event_tracker at CLK_HZ=1000, bpm=120: one tick every
// 125 cycles, so every timestamp and duration below is worked out by hand.
module tb_note_event_tracker;

   localparam int NV = 5;

   logic                 clk_in = 1'b0;
   logic                 rst_in;
   logic                 valid_note_in;
   logic [NV-1:0][3:0]   note_value_array;
   logic [NV-1:0][3:0]   octave_count;
   logic [NV-1:0]        note_on_in;
   logic [7:0]           bpm;
   logic                 evt_valid_out;
   logic                 evt_ready_in;
   logic [2:0]           evt_voice_out;
   logic [7:0]           evt_note_out;
   logic [7:0]           evt_duration_out;
   logic [31:0]          evt_start_out;
   logic                 evt_sat_out;
   logic                 overflow_out;
   logic                 tick_out;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   always #5 clk_in = ~clk_in;

   note_event_tracker #(
      .NUM_VOICES(NV), .CLK_HZ(1000), .TICKS_PER_BEAT(4),
      .DUR_WIDTH(8), .TS_WIDTH(32), .FIFO_DEPTH(16)
   ) dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .valid_note_in    (valid_note_in),
      .note_value_array (note_value_array),
      .octave_count     (octave_count),
      .note_on_in       (note_on_in),
      .bpm              (bpm),
      .evt_valid_out    (evt_valid_out),
      .evt_ready_in     (evt_ready_in),
      .evt_voice_out    (evt_voice_out),
      .evt_note_out     (evt_note_out),
      .evt_duration_out (evt_duration_out),
      .evt_start_out    (evt_start_out),
      .evt_sat_out      (evt_sat_out),
      .overflow_out     (overflow_out),
      .tick_out         (tick_out)
   );

   // cyc = index of the last rising edge; everything happens 1 time unit after it.
   task automatic adv();
      @(posedge clk_in);
      #1;
      cyc++;
   endtask

   task automatic goto(input int n);
      while (cyc < n) adv();
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_evt(input string tag, input int voice, input logic [7:0] note,
                          input int dur, input int start, input logic sat);
      chk({tag, ".valid"}, 64'(evt_valid_out), 64'd1);
      chk({tag, ".voice"}, 64'(evt_voice_out), 64'(voice));
      chk({tag, ".note"},  64'(evt_note_out), 64'(note));
      chk({tag, ".dur"},   64'(evt_duration_out), 64'(dur));
      chk({tag, ".start"}, 64'(evt_start_out), 64'(start));
      chk({tag, ".sat"},   64'(evt_sat_out), 64'(sat));
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, ".valid"}, 64'(evt_valid_out), 64'd0);
      chk({tag, ".voice"}, 64'(evt_voice_out), 64'd0);
      chk({tag, ".note"},  64'(evt_note_out), 64'd0);
      chk({tag, ".dur"},   64'(evt_duration_out), 64'd0);
      chk({tag, ".start"}, 64'(evt_start_out), 64'd0);
      chk({tag, ".sat"},   64'(evt_sat_out), 64'd0);
      chk({tag, ".ovf"},   64'(overflow_out), 64'd0);
      chk({tag, ".tick"},  64'(tick_out), 64'd0);
   endtask

   // Voice v plays pitch v in the given octave; mask selects which are on.
   task automatic set_voices(input logic [NV-1:0] mask, input int oct);
      for (int v = 0; v < NV; v++) begin
         note_value_array[v] = 4'(v);
         octave_count[v]     = 4'(oct);
      end
      note_on_in = mask;
   endtask

   initial begin
      logic [7:0] exp_note;
      int         exp_voice;
      rst_in = 1'b1; valid_note_in = 1'b0; bpm = 8'd120; evt_ready_in = 1'b0;
      note_on_in = '0; note_value_array = '0; octave_count = '0;
      adv(); adv(); adv();
      chk_quiet("reset");
      rst_in = 1'b0;
      cyc = 0;

      // Tick cadence: 480 per cycle against 60000 -> pulse after edge 125.
      for (int n = 1; n <= 129; n++) begin
         adv();
         chk("tick.cadence", 64'(tick_out), 64'(n % 125 == 0));
      end

      // Voice 0 C4 from edge 131 (tick count 1), held over ticks at edges 251..1126.
      goto(130); valid_note_in = 1'b1; set_voices(5'b00001, 4);
      goto(250); chk("tick.250", 64'(tick_out), 64'd1);
      goto(1130); note_on_in = '0;
      adv(); chk("c4.latency", 64'(evt_valid_out), 64'd0);
      adv(); chk_evt("c4", 0, 8'h04, 8, 1, 1'b0);
      adv(); chk_evt("c4.stable", 0, 8'h04, 8, 1, 1'b0);
      evt_ready_in = 1'b1;
      adv(); chk("c4.popped", 64'(evt_valid_out), 64'd0);

      // Voice 2 E4 at count 9; switch to G4 on the tick sampled at edge 1251.
      goto(1140); note_on_in = 5'b00100; note_value_array[2] = 4'd4; octave_count[2] = 4'd4;
      goto(1250); note_value_array[2] = 4'd7;
      adv(); chk("e4.latency", 64'(evt_valid_out), 64'd0);
      adv(); chk_evt("e4", 2, 8'h44, 1, 9, 1'b0);
      goto(1260); note_on_in = '0;
      adv(); adv(); chk_evt("g4", 2, 8'h74, 0, 10, 1'b0);

      // All five voices close in one sample -> drained lowest index first.
      goto(1270); set_voices(5'b11111, 3);
      goto(1280); note_on_in = '0;
      adv(); chk("alloff.latency", 64'(evt_valid_out), 64'd0);
      for (int v = 0; v < NV; v++) begin
         adv();
         chk_evt("alloff", v, {4'(v), 4'd3}, 0, 10, 1'b0);
      end
      adv(); chk("alloff.drained", 64'(evt_valid_out), 64'd0);

      // Consumer stalled: 16 events fill the FIFO, voice 1 then closes twice.
      goto(1290); evt_ready_in = 1'b0;
      for (int r = 0; r < 3; r++) begin
         goto(1300 + 20 * r); set_voices(5'b11111, 5 + r);
         goto(1310 + 20 * r); note_on_in = '0;
      end
      goto(1360); set_voices(5'b00001, 8);
      goto(1370); note_on_in = '0;
      goto(1380); set_voices(5'b00010, 9);
      goto(1385); note_on_in = '0;
      adv(); chk("ovf.first", 64'(overflow_out), 64'd0);
      chk_evt("full.head", 0, 8'h05, 0, 10, 1'b0);
      goto(1390); set_voices(5'b00010, 10);
      goto(1395); note_on_in = '0;
      adv(); chk("ovf.second", 64'(overflow_out), 64'd1);
      chk_evt("ovf.head", 0, 8'h05, 0, 10, 1'b0);
      goto(1400); evt_ready_in = 1'b1;
      for (int k = 0; k < 16; k++) begin
         exp_voice = (k < 15) ? (k % 5) : 0;
         exp_note  = (k < 15) ? {4'(k % 5), 4'(5 + k / 5)} : 8'h08;
         chk_evt("drain", exp_voice, exp_note, 0, 10, 1'b0);
         adv();
      end
      chk_evt("ovf.kept", 1, 8'h19, 0, 11, 1'b0);
      adv(); chk("drain.empty", 64'(evt_valid_out), 64'd0);
      chk("ovf.sticky", 64'(overflow_out), 64'd1);

      // Reset clears the sticky overflow; then a 300-tick note saturates.
      goto(1420); rst_in = 1'b1; note_on_in = '0;
      adv(); adv();
      chk_quiet("reset2");
      rst_in = 1'b0;
      cyc = 0;
      adv(); set_voices(5'b01000, 2);
      goto(37505); note_on_in = '0;
      adv(); chk("sat.latency", 64'(evt_valid_out), 64'd0);
      adv(); chk_evt("sat", 3, 8'h32, 255, 0, 1'b1);

      // Reset mid-note discards it; bpm=0 then halts the tick.
      goto(37510); set_voices(5'b10000, 6);
      goto(37600); chk("midnote.none", 64'(evt_valid_out), 64'd0);
      rst_in = 1'b1;
      adv(); chk_quiet("reset.midnote");
      rst_in = 1'b0; bpm = 8'd0; note_on_in = '0;
      cyc = 0;
      for (int n = 1; n <= 300; n++) begin
         adv();
         chk("bpm0.tick", 64'(tick_out), 64'd0);
         chk("bpm0.noevt", 64'(evt_valid_out), 64'd0);
      end
      bpm = 8'd120;
      cyc = 0;
      for (int n = 1; n <= 125; n++) begin
         adv();
         chk("resume.tick", 64'(tick_out), 64'(n == 125));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
